// File: rtl/multicycle_ctrl_fsm_if.sv
// ---------------------------------------------------------------------------
// multicycle_ctrl_fsm_if
//   Bundles the signals exchanged between the multi-cycle control FSM and
//   the shared RV32I datapath / memory port.
//
//   Handshake: mem_read / mem_write are requests held high by the
//   controller; the access completes in the cycle where mem_ready=1 is
//   sampled together with a request. There is no separate accept phase.
//
//   Modports
//     master : the controller (drives control, debug and status signals)
//     slave  : the datapath (drives opcode, zero, mem_ready)
//
//   Signals
//     opcode[6:0]   IR[6:0], stable from DECODE until the next FETCH
//     zero          ALU zero flag, valid in EXEC
//     mem_ready     memory completes the current access this cycle
//     pc_write, ir_write, iord, mem_read, mem_write, reg_write,
//     mem_to_reg, link_sel, alu_src, alu_op[1:0], pc_src[1:0]
//                   datapath controls
//     state[2:0]    current FSM state (debug)
//     illegal_instr sticky illegal-opcode flag
//     mem_fault     sticky memory-timeout flag
//     instret[31:0] retired-instruction counter
// ---------------------------------------------------------------------------
interface multicycle_ctrl_fsm_if;
    logic [6:0]  opcode;
    logic        zero;
    logic        mem_ready;
    logic        pc_write;
    logic        ir_write;
    logic        iord;
    logic        mem_read;
    logic        mem_write;
    logic        reg_write;
    logic        mem_to_reg;
    logic        link_sel;
    logic        alu_src;
    logic [1:0]  alu_op;
    logic [1:0]  pc_src;
    logic [2:0]  state;
    logic        illegal_instr;
    logic        mem_fault;
    logic [31:0] instret;

    modport master (
        input  opcode, zero, mem_ready,
        output pc_write, ir_write, iord, mem_read, mem_write, reg_write,
               mem_to_reg, link_sel, alu_src, alu_op, pc_src,
               state, illegal_instr, mem_fault, instret
    );

    modport slave (
        output opcode, zero, mem_ready,
        input  pc_write, ir_write, iord, mem_read, mem_write, reg_write,
               mem_to_reg, link_sel, alu_src, alu_op, pc_src,
               state, illegal_instr, mem_fault, instret
    );
endinterface

// File: rtl/multicycle_ctrl_fsm.sv
// ---------------------------------------------------------------------------
// multicycle_ctrl_fsm
//   Multi-cycle sequencer for the RV32I core: FETCH/DECODE/EXEC/MEM/WB over
//   a single memory port that stalls with mem_ready. Flags illegal opcodes
//   and memory timeouts (both sticky until reset) and counts retirements.
//
//   Optional feature macro: MC_CTRL_JUMP_EN
//     defined   : JAL/JALR execute (jump target to PC, PC+4 to rd)
//     undefined : JAL/JALR trap as illegal; link_sel is constant 0
//
//   Ports
//     clk   : rising-edge clock
//     reset : synchronous, active-high
//     bus   : multicycle_ctrl_fsm_if.master (controls, status, debug state)
//
//   Parameters
//     TIMEOUT_CYCLES : max mem_ready wait cycles in FETCH/MEM (0 = no limit)
//     CNT_W          : wait-counter width
// ---------------------------------------------------------------------------
module multicycle_ctrl_fsm #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int CNT_W          = $clog2(TIMEOUT_CYCLES + 1)
) (
    input logic                   clk,
    input logic                   reset,
    multicycle_ctrl_fsm_if.master bus
);
    // TIMEOUT_CYCLES=0 would give a zero-width counter; keep at least 1 bit.
    localparam int CW = (CNT_W < 1) ? 1 : CNT_W;
    localparam logic [CW-1:0] CNT_LAST =
        CW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
`ifdef MC_CTRL_JUMP_EN
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
`endif

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_TRAP   = 3'd5
    } state_t;

    state_t        st;
    logic [CW-1:0] wait_cnt;
    logic          illegal_q;
    logic          fault_q;
    logic [31:0]   instret_q;

    logic is_r, is_i, is_load, is_store, is_branch, is_jump, is_jalr, legal;
    logic timeout;

    always_comb begin
        is_r      = (bus.opcode == OP_R);
        is_i      = (bus.opcode == OP_I);
        is_load   = (bus.opcode == OP_LOAD);
        is_store  = (bus.opcode == OP_STORE);
        is_branch = (bus.opcode == OP_BRANCH);
`ifdef MC_CTRL_JUMP_EN
        is_jalr   = (bus.opcode == OP_JALR);
        is_jump   = (bus.opcode == OP_JAL) || is_jalr;
`else
        is_jalr   = 1'b0;
        is_jump   = 1'b0;
`endif
        legal     = is_r | is_i | is_load | is_store | is_branch | is_jump;
    end

    // mem_ready in the last allowed wait cycle takes priority over the fault.
    assign timeout = (TIMEOUT_CYCLES != 0) && !bus.mem_ready
                     && (wait_cnt == CNT_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            st        <= S_FETCH;
            wait_cnt  <= '0;
            illegal_q <= 1'b0;
            fault_q   <= 1'b0;
            instret_q <= '0;
        end else begin
            // Any cycle that does not keep waiting leaves the counter at 0.
            wait_cnt <= '0;
            case (st)
                S_FETCH: begin
                    if (bus.mem_ready) begin
                        st <= S_DECODE;
                    end else if (timeout) begin
                        st      <= S_TRAP;
                        fault_q <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + CW'(1);
                    end
                end
                S_DECODE: begin
                    if (legal) begin
                        st <= S_EXEC;
                    end else begin
                        st        <= S_TRAP;
                        illegal_q <= 1'b1;
                    end
                end
                S_EXEC: begin
                    if (is_r || is_i || is_jump) begin
                        st <= S_WB;
                    end else if (is_load || is_store) begin
                        st <= S_MEM;
                    end else if (is_branch) begin
                        st        <= S_FETCH;
                        instret_q <= instret_q + 32'd1;
                    end else begin
                        // Opcode changed under us after DECODE.
                        st        <= S_TRAP;
                        illegal_q <= 1'b1;
                    end
                end
                S_MEM: begin
                    if (bus.mem_ready) begin
                        if (is_load) begin
                            st <= S_WB;
                        end else begin
                            st        <= S_FETCH;
                            instret_q <= instret_q + 32'd1;
                        end
                    end else if (timeout) begin
                        st      <= S_TRAP;
                        fault_q <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + CW'(1);
                    end
                end
                S_WB: begin
                    st        <= S_FETCH;
                    instret_q <= instret_q + 32'd1;
                end
                S_TRAP:  st <= S_TRAP;
                default: st <= S_FETCH;
            endcase
        end
    end

    always_comb begin
        bus.pc_write   = 1'b0;
        bus.ir_write   = 1'b0;
        bus.iord       = 1'b0;
        bus.mem_read   = 1'b0;
        bus.mem_write  = 1'b0;
        bus.reg_write  = 1'b0;
        bus.mem_to_reg = 1'b0;
        bus.link_sel   = 1'b0;
        bus.alu_src    = 1'b0;
        bus.alu_op     = 2'b00;
        bus.pc_src     = 2'b00;
        case (st)
            S_FETCH: begin
                bus.mem_read = 1'b1;
                if (bus.mem_ready) begin
                    bus.ir_write = 1'b1;
                    bus.pc_write = 1'b1;
                end
            end
            S_EXEC: begin
                if (is_r) begin
                    bus.alu_op = 2'b10;
                end else if (is_i) begin
                    bus.alu_src = 1'b1;
                    bus.alu_op  = 2'b11;
                end else if (is_load || is_store) begin
                    bus.alu_src = 1'b1;
                end else if (is_branch) begin
                    bus.alu_op   = 2'b01;
                    bus.pc_src   = 2'b01;
                    bus.pc_write = bus.zero;
                end else if (is_jump) begin
                    bus.pc_write = 1'b1;
                    bus.pc_src   = 2'b10;
                    bus.alu_src  = is_jalr;
                end
            end
            S_MEM: begin
                bus.iord      = 1'b1;
                bus.mem_read  = is_load;
                bus.mem_write = is_store;
            end
            S_WB: begin
                bus.reg_write  = 1'b1;
                bus.mem_to_reg = is_load;
                bus.link_sel   = is_jump;
            end
            default: ;
        endcase
    end

    assign bus.state         = st;
    assign bus.illegal_instr = illegal_q;
    assign bus.mem_fault     = fault_q;
    assign bus.instret       = instret_q;

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// ---------------------------------------------------------------------------
// tb_multicycle_ctrl_fsm
//   Self-checking bench for multicycle_ctrl_fsm (TIMEOUT_CYCLES=4).
//   Each instruction is expanded by a reference model into a per-cycle list
//   of (mem_ready to apply, expected state/controls/flags/instret), which is
//   then driven and compared cycle by cycle.
// ---------------------------------------------------------------------------
module tb_multicycle_ctrl_fsm;
    localparam int TMO = 4;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    logic clk;
    logic reset;

    multicycle_ctrl_fsm_if bus ();

    multicycle_ctrl_fsm #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: observed no end of test, expected finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- reference model ----------------
    typedef struct packed {
        logic        rdy;
        logic [2:0]  st;
        logic [12:0] ctrl;
        logic        ill;
        logic        mf;
        logic [31:0] ir;
    } step_t;

    step_t       exp_q[$];
    logic        m_ill;
    logic        m_mf;
    logic [31:0] m_ir;
    bit          trapped;
    int unsigned n_vec;
    int unsigned n_err;

    // Control vector order:
    // pc_write ir_write iord mem_read mem_write reg_write mem_to_reg
    // link_sel alu_src alu_op[1:0] pc_src[1:0]
    function automatic logic [12:0] c(input logic pcw, input logic irw,
                                      input logic iord, input logic mr,
                                      input logic mw, input logic rw,
                                      input logic m2r, input logic ls,
                                      input logic as, input logic [1:0] aop,
                                      input logic [1:0] psrc);
        return {pcw, irw, iord, mr, mw, rw, m2r, ls, as, aop, psrc};
    endfunction

    function automatic bit jump_op(input logic [6:0] op);
`ifdef MC_CTRL_JUMP_EN
        return (op == OP_JAL) || (op == OP_JALR);
`else
        return 1'b0;
`endif
    endfunction

    function automatic bit legal(input logic [6:0] op);
        return (op == OP_R) || (op == OP_I) || (op == OP_LOAD) ||
               (op == OP_STORE) || (op == OP_BRANCH) || jump_op(op);
    endfunction

    function automatic logic rnd_bit();
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic push(input logic rdy, input logic [2:0] st,
                        input logic [12:0] ctrl);
        step_t s;
        s.rdy  = rdy;
        s.st   = st;
        s.ctrl = ctrl;
        s.ill  = m_ill;
        s.mf   = m_mf;
        s.ir   = m_ir;
        exp_q.push_back(s);
    endtask

    // A memory wait of 'stalls' not-ready cycles; TMO or more stalls means
    // the access gives up after exactly TMO of them.
    task automatic wait_phase(input logic [2:0] st, input int stalls,
                              input logic [12:0] ctrl, output bit ok);
        int n;
        n = (stalls >= TMO) ? TMO : stalls;
        for (int k = 0; k < n; k++) push(1'b0, st, ctrl);
        ok = (stalls < TMO);
        if (!ok) begin
            m_mf    = 1'b1;
            trapped = 1'b1;
        end
    endtask

    task automatic build_instr(input logic [6:0] op, input logic z,
                               input int fs, input int ms);
        bit ok;
        logic [12:0] mc;
        trapped = 1'b0;
        wait_phase(3'd0, fs, c(0,0,0,1,0,0,0,0,0,2'b00,2'b00), ok);
        if (!ok) return;
        push(1'b1, 3'd0, c(1,1,0,1,0,0,0,0,0,2'b00,2'b00));
        push(rnd_bit(), 3'd1, '0);
        if (!legal(op)) begin
            m_ill   = 1'b1;
            trapped = 1'b1;
            return;
        end
        if (op == OP_R) begin
            push(rnd_bit(), 3'd2, c(0,0,0,0,0,0,0,0,0,2'b10,2'b00));
            push(rnd_bit(), 3'd4, c(0,0,0,0,0,1,0,0,0,2'b00,2'b00));
            m_ir = m_ir + 1;
        end else if (op == OP_I) begin
            push(rnd_bit(), 3'd2, c(0,0,0,0,0,0,0,0,1,2'b11,2'b00));
            push(rnd_bit(), 3'd4, c(0,0,0,0,0,1,0,0,0,2'b00,2'b00));
            m_ir = m_ir + 1;
        end else if (op == OP_BRANCH) begin
            push(rnd_bit(), 3'd2, c(z,0,0,0,0,0,0,0,0,2'b01,2'b01));
            m_ir = m_ir + 1;
        end else if (jump_op(op)) begin
            push(rnd_bit(), 3'd2,
                 c(1,0,0,0,0,0,0,0,(op == OP_JALR),2'b00,2'b10));
            push(rnd_bit(), 3'd4, c(0,0,0,0,0,1,0,1,0,2'b00,2'b00));
            m_ir = m_ir + 1;
        end else begin
            push(rnd_bit(), 3'd2, c(0,0,0,0,0,0,0,0,1,2'b00,2'b00));
            mc = (op == OP_LOAD) ? c(0,0,1,1,0,0,0,0,0,2'b00,2'b00)
                                 : c(0,0,1,0,1,0,0,0,0,2'b00,2'b00);
            wait_phase(3'd3, ms, mc, ok);
            if (!ok) return;
            push(1'b1, 3'd3, mc);
            if (op == OP_LOAD)
                push(rnd_bit(), 3'd4, c(0,0,0,0,0,1,1,0,0,2'b00,2'b00));
            m_ir = m_ir + 1;
        end
    endtask

    // ---------------- driver / scoreboard ----------------
    function automatic logic [12:0] dut_ctrl();
        return {bus.pc_write, bus.ir_write, bus.iord, bus.mem_read,
                bus.mem_write, bus.reg_write, bus.mem_to_reg, bus.link_sel,
                bus.alu_src, bus.alu_op, bus.pc_src};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h (t=%0t)", tag, obs, exp,
                   $time);
        end
    endtask

    // Each step starts just after a falling edge: drive, settle, compare,
    // then advance to the next falling edge (a rising edge in between).
    task automatic run_steps(input int max_n);
        step_t s;
        int n;
        n = 0;
        while (exp_q.size() > 0 && n < max_n) begin
            s = exp_q.pop_front();
            bus.mem_ready = s.rdy;
            #1;
            check("state",   32'(bus.state),         32'(s.st));
            check("ctrl",    32'(dut_ctrl()),        32'(s.ctrl));
            check("flags",   32'({bus.illegal_instr, bus.mem_fault}),
                             32'({s.ill, s.mf}));
            check("instret", bus.instret,            s.ir);
            @(negedge clk);
            n++;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        bus.mem_ready = rnd_bit();
        @(negedge clk);
        reset = 1'b0;
        m_ill = 1'b0;
        m_mf  = 1'b0;
        m_ir  = '0;
        #1;
        check("rst_state",   32'(bus.state), 32'd0);
        check("rst_flags",   32'({bus.illegal_instr, bus.mem_fault}), 32'd0);
        check("rst_instret", bus.instret, 32'd0);
    endtask

    task automatic run_instr(input logic [6:0] op, input logic z,
                             input int fs, input int ms, input int trap_cyc);
        bus.opcode = op;
        bus.zero   = z;
        build_instr(op, z, fs, ms);
        run_steps(1000);
        if (trapped) begin
            for (int k = 0; k < trap_cyc; k++)
                push(rnd_bit(), 3'd5, '0);
            run_steps(1000);
            do_reset();
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [6:0] ops[5];
        logic [6:0] op;
        int         fs;
        int         ms;

        n_vec = 0;
        n_err = 0;
        m_ill = 1'b0;
        m_mf  = 1'b0;
        m_ir  = '0;
        trapped = 1'b0;
        ops[0] = OP_R;     ops[1] = OP_I;      ops[2] = OP_LOAD;
        ops[3] = OP_STORE; ops[4] = OP_BRANCH;

        reset         = 1'b1;
        bus.opcode    = OP_R;
        bus.zero      = 1'b0;
        bus.mem_ready = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        #1;
        check("rst_state",   32'(bus.state), 32'd0);
        check("rst_flags",   32'({bus.illegal_instr, bus.mem_fault}), 32'd0);
        check("rst_instret", bus.instret, 32'd0);

        // R-type, zero-wait memory.
        run_instr(OP_R, 1'b0, 0, 0, 0);
        // Load, 3 wait cycles in FETCH and in MEM (ready on the 4th).
        run_instr(OP_LOAD, 1'b0, 3, 3, 0);
        // Branch taken then not taken.
        run_instr(OP_BRANCH, 1'b1, 0, 0, 0);
        run_instr(OP_BRANCH, 1'b0, 0, 0, 0);
        // Store, I-type.
        run_instr(OP_STORE, 1'b0, 1, 2, 0);
        run_instr(OP_I, 1'b0, 0, 0, 0);
        // Illegal opcode: TRAP held 20 cycles, then reset.
        run_instr(7'b0000000, 1'b0, 0, 0, 20);
        // Fetch timeout, then the boundary where ready wins.
        run_instr(OP_R, 1'b0, TMO, 0, 5);
        run_instr(OP_R, 1'b0, TMO - 1, 0, 0);
        // MEM timeout on a load.
        run_instr(OP_LOAD, 1'b0, 0, TMO, 3);
        // Jumps: executed with the feature, trapped without it.
        run_instr(OP_JAL, 1'b0, 0, 0, 4);
        run_instr(OP_JALR, 1'b0, 1, 0, 4);

        // Reset while a store waits in MEM: access abandoned, no retire.
        run_instr(OP_R, 1'b0, 0, 0, 0);
        bus.opcode = OP_STORE;
        bus.zero   = 1'b0;
        build_instr(OP_STORE, 1'b0, 0, 3);
        run_steps(4);
        exp_q.delete();
        do_reset();

        // Randomized instruction stream.
        for (int i = 0; i < 300; i++) begin
            case ($urandom_range(0, 11))
                0:       op = 7'($urandom_range(0, 127));
                1:       op = ($urandom_range(0, 1) != 0) ? OP_JAL : OP_JALR;
                default: op = ops[$urandom_range(0, 4)];
            endcase
            fs = ($urandom_range(0, 11) == 0) ? $urandom_range(TMO, TMO + 2)
                                              : $urandom_range(0, TMO - 1);
            ms = ($urandom_range(0, 11) == 0) ? $urandom_range(TMO, TMO + 2)
                                              : $urandom_range(0, TMO - 1);
            run_instr(op, rnd_bit(), fs, ms, $urandom_range(1, 4));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/multicycle_ctrl_fsm.md
Name: multicycle_ctrl_fsm

Overview:
- Multi-cycle sequencer for the RV32I core.
- Drives the shared datapath through FETCH/DECODE/EXEC/MEM/WB, one instruction at a time, over a single memory port that holds off with mem_ready.
- Keeps the ALUOp encoding used by the ALU decoder: 00 add, 01 branch compare, 10 R-type, 11 I-type.
- Reports illegal opcodes and memory timeouts, and counts retired instructions.

Parameters:
- TIMEOUT_CYCLES, 255: maximum wait cycles for mem_ready in FETCH or MEM. 0 disables the timeout.
- CNT_W, $clog2(TIMEOUT_CYCLES+1): width of the wait counter.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- opcode  input  7  IR[6:0]; stable from DECODE until the next FETCH.
- zero  input  1  ALU zero flag, valid in EXEC.
- mem_ready  input  1  memory completes the current access this cycle.
- pc_write  output  1  load PC this cycle.
- ir_write  output  1  load IR with memory read data.
- iord  output  1  memory address source: 0 = PC, 1 = ALU result.
- mem_read  output  1  memory read request.
- mem_write  output  1  memory write request.
- reg_write  output  1  register file write enable.
- mem_to_reg  output  1  writeback source is the memory data register.
- link_sel  output  1  writeback source is PC+4 (jumps).
- alu_src  output  1  ALU B operand: 0 = rs2, 1 = immediate.
- alu_op  output  2  ALUOp to the ALU decoder.
- pc_src  output  2  PC source: 00 = PC+4, 01 = branch target, 10 = jump target.
- state  output  3  current state, for debug.
- illegal_instr  output  1  sticky illegal-opcode flag.
- mem_fault  output  1  sticky memory-timeout flag.
- instret  output  32  retired-instruction counter.

Behaviour:
- State encoding: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=5. Codes 6 and 7 go to FETCH next cycle with all outputs 0.
- All control outputs are combinational from state, opcode, zero and mem_ready. Any output not listed for a state is 0.
- Reset: state=FETCH, wait counter=0, instret=0, illegal_instr=0, mem_fault=0. Reset mid-access abandons the access, with no write, retire or flag.
- FETCH:
  - mem_read=1, iord=0, continuously.
  - On mem_ready: ir_write=1, pc_write=1, pc_src=00, then go to DECODE.
- DECODE: no outputs. Next state:
  - EXEC for 0110011, 0010011, 0000011, 0100011, 1100011.
  - TRAP otherwise; illegal_instr set at entry.
- EXEC:
  - R-type: alu_src=0, alu_op=10, go to WB.
  - I-type: alu_src=1, alu_op=11, go to WB.
  - Load/store: alu_src=1, alu_op=00, go to MEM.
  - Branch: alu_src=0, alu_op=01, pc_src=01, pc_write=zero, go to FETCH and retire.
- MEM (iord=1):
  - Load: mem_read=1. On mem_ready go to WB.
  - Store: mem_write=1. On mem_ready go to FETCH and retire.
  - Request is held high until mem_ready.
- WB: reg_write=1, mem_to_reg=1 only for loads. Go to FETCH and retire.
- TRAP: all control outputs 0; held until reset.
- Wait counter:
  - Cleared on every state change.
  - Increments each FETCH/MEM cycle with mem_ready=0.
  - If it equals TIMEOUT_CYCLES-1 and mem_ready=0: go to TRAP and set mem_fault.
  - mem_ready in that same cycle wins: normal completion, no fault.
- Retire: instret+1 in the cycle the FSM transitions to FETCH from EXEC, MEM or WB. Wraps 0xFFFFFFFF to 0.
- Latency with zero-wait memory: R/I = 4 cycles, load = 5, store = 4, branch = 3.

Optional Feature:
- MC_CTRL_JUMP_EN defined:
  - JAL (1101111) and JALR (1100111) are legal.
  - EXEC: pc_write=1, pc_src=10, alu_op=00, alu_src=1 for JALR else 0. Go to WB.
  - WB: reg_write=1, link_sel=1, then retire.
- Undefined: both opcodes go to TRAP with illegal_instr set; link_sel tied to 0.

Test Plan:
- mem_ready=1 always, opcode=0110011: states 0,1,2,4,0 over 4 cycles; reg_write=1 in WB, alu_op=10 in EXEC; instret 0 to 1.
- Load, mem_ready low 3 cycles in each of FETCH and MEM: mem_read held, then WB with mem_to_reg=1; total 11 cycles; instret=1.
- Branch 1100011 with zero=1, then zero=0: EXEC pc_write=1 with pc_src=01, then pc_write=0; each takes 3 cycles; instret=2.
- opcode=0000000: DECODE to TRAP; illegal_instr=1; outputs 0 for 20 cycles; reset returns state=0 and clears the flag.
- TIMEOUT_CYCLES=4, mem_ready=0 in FETCH: TRAP after the 4th wait cycle, mem_fault=1. Rerun with mem_ready=1 on the 4th cycle: DECODE, no fault.
- MC_CTRL_JUMP_EN defined, opcode=1101111: EXEC pc_write=1 with pc_src=10; WB link_sel=1 and reg_write=1. Macro undefined: TRAP.
